// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with selectable registered or
// first-word-fall-through output, occupancy-based status flags, sticky
// overflow/underflow error flags and a synchronous flush.
module fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 1,
    parameter int FWFT      = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         buf_in,
    input  logic                      wr_en,
    input  logic                      rd_en,
    input  logic                      flush,
    input  logic                      clr_err,
    output logic [DATA_W-1:0]         buf_out,
    output logic                      buf_empty,
    output logic                      buf_full,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [$clog2(DEPTH):0]    fifo_cnt,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AFULL = CW'(AFULL_TH);
    localparam logic [CW-1:0] CNT_AEMPT = CW'(AEMPTY_TH);

    // Storage and state registers.
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     cnt_r;
    logic              empty_r;
    logic              full_r;
    logic              afull_r;
    logic              aempty_r;
    logic              ovf_r;
    logic              udf_r;

    // Per-cycle decisions.
    logic              rd_ok_s;
    logic              wr_ok_s;
    logic              ovf_set_s;
    logic              udf_set_s;
    logic [CW-1:0]     cnt_next_s;

    // Accept/reject decisions; flush masks both requests and any error.
    always_comb begin
        rd_ok_s    = 1'b0;
        wr_ok_s    = 1'b0;
        ovf_set_s  = 1'b0;
        udf_set_s  = 1'b0;
        cnt_next_s = cnt_r;
        if (flush) begin
            cnt_next_s = CNT_ZERO;
        end else begin
            rd_ok_s   = rd_en & ~empty_r;
            wr_ok_s   = wr_en & (~full_r | rd_ok_s);
            ovf_set_s = wr_en & ~wr_ok_s;
            udf_set_s = rd_en & ~rd_ok_s;
            if (wr_ok_s && !rd_ok_s) begin
                cnt_next_s = cnt_r + CNT_ONE;
            end else if (rd_ok_s && !wr_ok_s) begin
                cnt_next_s = cnt_r - CNT_ONE;
            end else begin
                cnt_next_s = cnt_r;
            end
        end
    end

    // Pointers, occupancy and flags; flags are registered from the next count
    // so they change on the same edge as fifo_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            cnt_r    <= CNT_ZERO;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            afull_r  <= 1'b0;
            aempty_r <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr_r <= PTR_ZERO;
                rd_ptr_r <= PTR_ZERO;
            end else begin
                if (wr_ok_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
                if (rd_ok_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
            end
            cnt_r    <= cnt_next_s;
            empty_r  <= (cnt_next_s == CNT_ZERO);
            full_r   <= (cnt_next_s == CNT_DEPTH);
            afull_r  <= (cnt_next_s >= CNT_AFULL);
            aempty_r <= (cnt_next_s <= CNT_AEMPT);
        end
    end

    // Sticky error flags; a new error in the same cycle beats clr_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (clr_err) begin
                ovf_r <= 1'b0;
            end
            if (udf_set_s) begin
                udf_r <= 1'b1;
            end else if (clr_err) begin
                udf_r <= 1'b0;
            end
        end
    end

    // Data storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= buf_in;
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_out
            logic [DATA_W-1:0] out_r;

            // Registered read port: load the head word on an accepted pop.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_r <= {DATA_W{1'b0}};
                end else if (rd_ok_s) begin
                    out_r <= mem_r[rd_ptr_r];
                end
            end

            assign buf_out = out_r;
        end else begin : g_fwft_out
            logic [DATA_W-1:0] head_s;

            // Head-of-queue is shown directly; zero while empty.
            always_comb begin
                head_s = {DATA_W{1'b0}};
                if (empty_r) begin
                    head_s = {DATA_W{1'b0}};
                end else begin
                    head_s = mem_r[rd_ptr_r];
                end
            end

            assign buf_out = head_s;
        end
    endgenerate

    assign buf_empty    = empty_r;
    assign buf_full     = full_r;
    assign almost_full  = afull_r;
    assign almost_empty = aempty_r;
    assign fifo_cnt     = cnt_r;
    assign overflow     = ovf_r;
    assign underflow    = udf_r;

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: one registered-output and one FWFT instance share the
// same stimulus. A constant vector table covers the directed scenarios; a
// queue scoreboard covers long streams, pointer wrap and mid-stream reset.
module tb_fifo_param;

    logic       clk;
    logic       rst_n;
    logic [7:0] buf_in;
    logic       wr_en;
    logic       rd_en;
    logic       flush;
    logic       clr_err;

    logic [7:0] out0, out1;
    logic       empty0, full0, af0, ae0, ovf0, udf0;
    logic       empty1, full1, af1, ae1, ovf1, udf1;
    logic [3:0] cnt0, cnt1;

    int checks;
    int failures;

    fifo_param #(.DATA_W(8), .DEPTH(8), .FWFT(0)) u_reg (
        .clk(clk), .rst_n(rst_n), .buf_in(buf_in), .wr_en(wr_en), .rd_en(rd_en),
        .flush(flush), .clr_err(clr_err), .buf_out(out0), .buf_empty(empty0),
        .buf_full(full0), .almost_full(af0), .almost_empty(ae0), .fifo_cnt(cnt0),
        .overflow(ovf0), .underflow(udf0)
    );

    fifo_param #(.DATA_W(8), .DEPTH(8), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .buf_in(buf_in), .wr_en(wr_en), .rd_en(rd_en),
        .flush(flush), .clr_err(clr_err), .buf_out(out1), .buf_empty(empty1),
        .buf_full(full1), .almost_full(af1), .almost_empty(ae1), .fifo_cnt(cnt1),
        .overflow(ovf1), .underflow(udf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr, rd, fl, clr;
        logic [7:0] din;
        int         cnt;
        logic       ovf, udf;
        logic [7:0] o0, o1;
    } vec_t;

    vec_t vt[$];

    // Scoreboard state
    logic [7:0] sb_q[$];
    logic       m_ovf, m_udf;
    logic [7:0] m_last0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Compare every output of both instances against an expected state.
    task automatic chk_all(input string tag, input int cnt, input logic ovf,
                           input logic udf, input logic [7:0] o0, input logic [7:0] o1);
        chk({tag, " cnt"},    int'(cnt0), cnt);
        chk({tag, " cnt_f"},  int'(cnt1), cnt);
        chk({tag, " empty"},  int'(empty0), int'(cnt == 0));
        chk({tag, " empty_f"},int'(empty1), int'(cnt == 0));
        chk({tag, " full"},   int'(full0), int'(cnt == 8));
        chk({tag, " full_f"}, int'(full1), int'(cnt == 8));
        chk({tag, " afull"},  int'(af0), int'(cnt >= 6));
        chk({tag, " aempty"}, int'(ae0), int'(cnt <= 1));
        chk({tag, " ovf"},    int'(ovf0), int'(ovf));
        chk({tag, " ovf_f"},  int'(ovf1), int'(ovf));
        chk({tag, " udf"},    int'(udf0), int'(udf));
        chk({tag, " udf_f"},  int'(udf1), int'(udf));
        chk({tag, " out_reg"},  int'(out0), int'(o0));
        chk({tag, " out_fwft"}, int'(out1), int'(o1));
    endtask

    function automatic void add(input logic w, input logic r, input logic f, input logic c,
                                input logic [7:0] d, input int cnt, input logic ovf,
                                input logic udf, input logic [7:0] o0, input logic [7:0] o1);
        vec_t v;
        v.wr = w; v.rd = r; v.fl = f; v.clr = c; v.din = d;
        v.cnt = cnt; v.ovf = ovf; v.udf = udf; v.o0 = o0; v.o1 = o1;
        vt.push_back(v);
    endfunction

    task automatic drive(input logic w, input logic r, input logic f, input logic c,
                         input logic [7:0] d);
        wr_en = w; rd_en = r; flush = f; clr_err = c; buf_in = d;
    endtask

    // One scoreboard-checked cycle: the model decides acceptance, expected
    // data is queued on write and popped/compared on read.
    task automatic cyc(input string tag, input logic w, input logic r, input logic f,
                       input logic c, input logic [7:0] d);
        logic rd_ok, wr_ok;
        logic [7:0] popped;
        rd_ok = !f && r && (sb_q.size() > 0);
        wr_ok = !f && w && ((sb_q.size() < 8) || rd_ok);
        drive(w, r, f, c, d);
        if (rd_ok) chk({tag, " fwft_head"}, int'(out1), int'(sb_q[0]));
        if (f) begin
            sb_q.delete();
        end else begin
            if (rd_ok) begin
                popped  = sb_q.pop_front();
                m_last0 = popped;
            end
            if (wr_ok) sb_q.push_back(d);
        end
        if (!f && w && !wr_ok) m_ovf = 1'b1;
        else if (c)            m_ovf = 1'b0;
        if (!f && r && !rd_ok) m_udf = 1'b1;
        else if (c)            m_udf = 1'b0;
        @(posedge clk);
        #1;
        chk_all(tag, sb_q.size(), m_ovf, m_udf, m_last0,
                (sb_q.size() > 0) ? sb_q[0] : 8'd0);
    endtask

    initial begin
        logic [7:0] dv [8];
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        dv = '{8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd99};

        // Directed vectors: inputs for one edge, expected state after it.
        add(1'b1,1'b0,1'b0,1'b0, 8'd1,  1, 1'b0,1'b0, 8'd0, 8'd1);
        add(1'b1,1'b1,1'b0,1'b0, 8'd2,  1, 1'b0,1'b0, 8'd1, 8'd2);
        add(1'b0,1'b1,1'b0,1'b0, 8'd0,  0, 1'b0,1'b0, 8'd2, 8'd0);
        for (int k = 1; k <= 8; k++)
            add(1'b1,1'b0,1'b0,1'b0, 8'(10*k), k, 1'b0,1'b0, 8'd2, 8'd10);
        add(1'b1,1'b0,1'b0,1'b0, 8'd90, 8, 1'b1,1'b0, 8'd2, 8'd10);
        add(1'b0,1'b0,1'b0,1'b1, 8'd0,  8, 1'b0,1'b0, 8'd2, 8'd10);
        add(1'b1,1'b1,1'b0,1'b0, 8'd99, 8, 1'b0,1'b0, 8'd10, 8'd20);
        for (int k = 0; k < 8; k++)
            add(1'b0,1'b1,1'b0,1'b0, 8'd0, 7-k, 1'b0,1'b0, dv[k],
                (k < 7) ? dv[k+1] : 8'd0);
        add(1'b1,1'b1,1'b0,1'b0, 8'd5,  1, 1'b0,1'b1, 8'd99, 8'd5);
        add(1'b0,1'b0,1'b0,1'b1, 8'd0,  1, 1'b0,1'b0, 8'd99, 8'd5);
        add(1'b0,1'b1,1'b0,1'b0, 8'd0,  0, 1'b0,1'b0, 8'd5, 8'd0);
        add(1'b0,1'b1,1'b0,1'b1, 8'd0,  0, 1'b0,1'b1, 8'd5, 8'd0);
        add(1'b0,1'b0,1'b0,1'b1, 8'd0,  0, 1'b0,1'b0, 8'd5, 8'd0);
        add(1'b1,1'b0,1'b0,1'b0, 8'd11, 1, 1'b0,1'b0, 8'd5, 8'd11);
        add(1'b1,1'b0,1'b0,1'b0, 8'd12, 2, 1'b0,1'b0, 8'd5, 8'd11);
        add(1'b1,1'b0,1'b0,1'b0, 8'd13, 3, 1'b0,1'b0, 8'd5, 8'd11);
        add(1'b1,1'b0,1'b1,1'b0, 8'd14, 0, 1'b0,1'b0, 8'd5, 8'd0);
        add(1'b0,1'b1,1'b1,1'b0, 8'd0,  0, 1'b0,1'b0, 8'd5, 8'd0);

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 1'b0, 1'b0, 8'd0, 8'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].wr, vt[i].rd, vt[i].fl, vt[i].clr, vt[i].din);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vt[i].cnt, vt[i].ovf, vt[i].udf,
                    vt[i].o0, vt[i].o1);
        end

        // Scoreboard picks up from the state the table leaves behind.
        sb_q.delete();
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_last0 = 8'd5;

        // 12 pushes / 12 pops from zeroed pointers so both pointers wrap.
        cyc("wrap_flush", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        for (int k = 0; k < 4; k++) cyc("wrap_push", 1'b1, 1'b0, 1'b0, 1'b0, 8'(100 + k));
        for (int k = 4; k < 12; k++) cyc("wrap_both", 1'b1, 1'b1, 1'b0, 1'b0, 8'(100 + k));
        for (int k = 0; k < 4; k++) cyc("wrap_pop", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);

        // Random stream alternating fill-biased and drain-biased phases.
        for (int i = 0; i < 240; i++) begin
            logic w, r, c, f;
            if (((i / 30) % 2) == 0) begin
                w = ($urandom_range(3, 0) != 0);
                r = ($urandom_range(3, 0) == 0);
            end else begin
                w = ($urandom_range(3, 0) == 0);
                r = ($urandom_range(3, 0) != 0);
            end
            c = ($urandom_range(15, 0) == 0);
            f = ($urandom_range(63, 0) == 0);
            cyc("rand", w, r, f, c, 8'($urandom_range(255, 0)));
        end

        // Asynchronous reset in the middle of a cycle, away from any edge.
        for (int k = 0; k < 5; k++) cyc("pre_rst", 1'b1, 1'b0, 1'b0, 1'b1, 8'(200 + k));
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 1'b0, 1'b0, 8'd0, 8'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        chk_all("rst_hold", 0, 1'b0, 1'b0, 8'd0, 8'd0);
        rst_n = 1'b1;
        sb_q.delete();
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_last0 = 8'd0;
        cyc("post_rst_push", 1'b1, 1'b0, 1'b0, 1'b0, 8'd77);
        cyc("post_rst_pop",  1'b0, 1'b1, 1'b0, 1'b0, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
